// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIF FFT butterfly sequencer: read/twiddle address generation,
// write-back address FIFO and stage barrier. Optional `stall` input via FFT_SCHED_STALL_EN.
module fft_bfly_sched #(
  parameter int N_LOG2   = 6,
  parameter int BFLY_LAT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
`ifdef FFT_SCHED_STALL_EN
  input  logic                        stall,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_LOG2)-1:0]   stage,
  output logic                        rd_en,
  output logic [N_LOG2-1:0]           rd_addr_a,
  output logic [N_LOG2-1:0]           rd_addr_b,
  output logic [N_LOG2-2:0]           tw_idx,
  output logic                        bfly_in_valid,
  input  logic                        bfly_out_valid,
  output logic                        wr_en,
  output logic [N_LOG2-1:0]           wr_addr_a,
  output logic [N_LOG2-1:0]           wr_addr_b,
  output logic                        err
);

  localparam int SW   = $clog2(N_LOG2);
  localparam int KW   = N_LOG2 - 1;
  localparam int HALF = 1 << (N_LOG2 - 1);
  localparam int D    = BFLY_LAT + 2;
  localparam int PW   = $clog2(D);
  localparam int CW   = $clog2(D + 1);
  localparam logic [N_LOG2-1:0] HALF_V = N_LOG2'(HALF);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [KW-1:0]      r_k;
  logic [SW-1:0]      r_s;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_wp, r_rp;
  logic [N_LOG2-1:0]  r_fa [D];
  logic [N_LOG2-1:0]  r_fb [D];
  logic               r_in_valid;
  logic               r_err;

  logic               w_stall, w_full, w_empty, w_issue_try, w_rd, w_wr;
  logic               w_last_k, w_last_s, w_drained, w_in_issue;
  logic [N_LOG2-1:0]  w_span, w_mask, w_kx, w_j, w_a, w_b;

`ifdef FFT_SCHED_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_in_issue  = (r_state == S_ISSUE);
  assign w_full      = (r_cnt == CW'(D));
  assign w_empty     = (r_cnt == '0);
  assign w_issue_try = w_in_issue && !w_stall;
  assign w_rd        = w_issue_try && !w_full;
  assign w_wr        = bfly_out_valid && !w_empty;
  assign w_last_k    = (r_k == KW'(HALF - 1));
  assign w_last_s    = (r_s == SW'(N_LOG2 - 1));
  assign w_drained   = (r_state == S_DRAIN) && w_empty;

  // span = N>>(s+1); grp*2*span + j is k with its high (group) bits shifted up by one
  assign w_span = HALF_V >> r_s;
  assign w_mask = w_span - N_LOG2'(1);
  assign w_kx   = {1'b0, r_k};
  assign w_j    = w_kx & w_mask;
  assign w_a    = ((w_kx & ~w_mask) << 1) | w_j;
  assign w_b    = w_a | w_span;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (w_rd && w_last_k) w_next = S_DRAIN;
      S_DRAIN: if (w_empty) w_next = w_last_s ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k <= '0;
      r_s <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_k <= '0;
      r_s <= '0;
    end else if (w_rd) begin
      r_k <= r_k + KW'(1);
    end else if (w_drained && !w_last_s) begin
      r_k <= '0;
      r_s <= r_s + SW'(1);
    end
  end

  // Occupancy of the write-back FIFO doubles as the outstanding-butterfly count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        r_fa[i] <= '0;
        r_fb[i] <= '0;
      end
    end else begin
      if (w_rd && !w_wr)      r_cnt <= r_cnt + CW'(1);
      else if (!w_rd && w_wr) r_cnt <= r_cnt - CW'(1);
      if (w_rd) begin
        r_fa[r_wp] <= w_a;
        r_fb[r_wp] <= w_b;
        r_wp       <= (r_wp == PW'(D - 1)) ? '0 : r_wp + PW'(1);
      end
      if (w_wr) r_rp <= (r_rp == PW'(D - 1)) ? '0 : r_rp + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_in_valid <= w_rd;
      if ((bfly_out_valid && w_empty) || (w_issue_try && w_full)) r_err <= 1'b1;
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign stage         = r_s;
  assign rd_en         = w_rd;
  assign rd_addr_a     = w_in_issue ? w_a : '0;
  assign rd_addr_b     = w_in_issue ? w_b : '0;
  assign tw_idx        = w_in_issue ? KW'(w_j << r_s) : '0;
  assign bfly_in_valid = r_in_valid;
  assign wr_en         = w_wr;
  assign wr_addr_a     = w_wr ? r_fa[r_rp] : '0;
  assign wr_addr_b     = w_wr ? r_fb[r_rp] : '0;
  assign err           = r_err;

endmodule

// File: doc/fft_bfly_sched.md
# fft_bfly_sched

In-place radix-2 decimation-in-frequency (DIF) FFT sequencer for the shared `butterfly_fp` datapath. It walks all stages of an N-point transform and issues one butterfly per cycle. For each butterfly it generates the operand read addresses and the twiddle index for a single dual-port sample memory. It tracks the butterfly pipeline and generates the write-back addresses. It sits between the sample buffer and `butterfly_fp`, and signals completion to the OFDM symbol controller.

## Interface
- `N_LOG2`, 6: log2 of the FFT size N (N = 2^N_LOG2); legal range 2..10.
- `BFLY_LAT`, 4: `butterfly_fp` latency, in cycles, from its input-valid to `out_valid`.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a transform; sampled only in IDLE.
- `busy` out 1: transform in progress.
- `done` out 1: one-cycle pulse when the last write-back of the last stage has completed.
- `stage` out `$clog2(N_LOG2)`: current stage index, 0..N_LOG2-1.
- `rd_en` out 1: memory read strobe for both ports.
- `rd_addr_a`, `rd_addr_b` out N_LOG2: read addresses for operands A and B.
- `tw_idx` out N_LOG2-1: twiddle ROM index (exponent of W_N), aligned with `rd_en`.
- `bfly_in_valid` out 1: `rd_en` delayed one cycle (memory read latency is 1); drives the butterfly's input valid.
- `bfly_out_valid` in 1: `out_valid` from `butterfly_fp`.
- `wr_en` out 1: write strobe for both ports; equals `bfly_out_valid` while a butterfly is outstanding.
- `wr_addr_a`, `wr_addr_b` out N_LOG2: write addresses for X and Y (same pair as the originating read).
- `err` out 1: sticky error flag; cleared only by reset.
- `stall` in 1: present only with `FFT_SCHED_STALL_EN` (see Configuration).

## Operation
- **States:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE → ISSUE:** on `start`=1. The butterfly counter k and the stage counter s are cleared.
- **ISSUE:**
  - Each cycle not stalled: `rd_en`=1 and k increments.
  - After k = N/2-1 is issued, go to DRAIN.
- **Address generation** for stage s, butterfly k:
  - span = N>>(s+1), j = k mod span, grp = k / span.
  - `rd_addr_a` = grp·2·span + j; `rd_addr_b` = `rd_addr_a` + span; `tw_idx` = j<<s.
  - All are pure shift/mask logic; no dividers.
- **Write-back address FIFO:**
  - Each issued {a, b} pair is pushed into an internal FIFO of depth BFLY_LAT+2.
  - On `bfly_out_valid` the head is popped and presented on `wr_addr_a`/`wr_addr_b` in the same cycle, with `wr_en`=1.
- **Outstanding counter:** +1 on `rd_en`, −1 on `wr_en`; both in one cycle leaves it unchanged.
- **DRAIN:** waits for outstanding = 0. This is the read-after-write hazard barrier: stage s+1 reads locations written by stage s.
  - If s < N_LOG2-1: s increments, k clears, go to ISSUE.
  - Otherwise go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **`start` while not IDLE:** ignored.
- **Error cases:** `err` is set, and the condition is otherwise ignored (no pop, counter unchanged), when either:
  - `bfly_out_valid`=1 with the FIFO empty, or
  - outstanding is already BFLY_LAT+2 when an issue is attempted.
- **Output order:** output is left bit-reversed in memory; reordering is not this block's job.

## Timing
- **Reset values:** all outputs 0; state IDLE; all counters and the FIFO cleared.
- **Reset mid-transform:** immediate abort; memory contents are undefined. Later `bfly_out_valid` pulses set `err`.
- **Start:** `start` high in IDLE at cycle t gives the first `rd_en` at t+1. `busy` is high from t+1 through the DONE cycle inclusive.
- **Pipeline:** `bfly_in_valid` follows `rd_en` by 1 cycle. With `butterfly_fp` in the loop, `wr_en` follows `rd_en` by BFLY_LAT+1 cycles.
- **Stage period (no stall):** N/2 + BFLY_LAT + 2 cycles from a stage's first `rd_en` to the next stage's first `rd_en`. The DRAIN exit is decided on the cycle after the last `wr_en`.
- **`done` timing:** asserted 2 cycles after the final `wr_en`.
- **`stage` output:** updates in the first ISSUE cycle of each stage.

## Configuration
- **`FFT_SCHED_STALL_EN` defined:**
  - The `stall` input exists.
  - `stall`=1 in ISSUE suppresses `rd_en` that cycle; k and the addresses hold.
  - The DRAIN, write-back and `done` paths are unaffected.
- **Not defined:** the port is absent and the block behaves as if `stall`=0.

## Test plan
- **Stage-0 addresses:** N_LOG2=3, BFLY_LAT=4, `start` at cycle 0.
  - Reads (0,4)tw0, (1,5)tw1, (2,6)tw2, (3,7)tw3 on cycles 1–4.
  - Writes with the same pairs on cycles 6–9.
- **Later stages and completion:** same setup.
  - Stage 1 reads (0,2)tw0, (1,3)tw2, (4,6)tw0, (5,7)tw2 on cycles 11–14.
  - Stage 2 reads (0,1), (2,3), (4,5), (6,7), all tw0, on cycles 21–24.
  - `done` on cycle 31; `busy` low on cycle 32.
- **Mid-run reset:** `reset` low at cycle 13.
  - All outputs 0 immediately.
  - A new `start` then restarts at stage 0 with addresses (0,4).
  - `err` is set if the stale butterfly outputs arrive.
- **Ignored start and spurious output:**
  - `start` held high throughout the run: a single transform only; `done` pulses once.
  - `bfly_out_valid` pulsed while IDLE: `err`=1 and no `wr_en`.
- **Stall (`FFT_SCHED_STALL_EN`):** `stall`=1 on cycles 2–3.
  - Pair (1,5) issues on cycle 4 instead of 2.
  - The stage-1 start moves to cycle 13.
- **Default size:** N_LOG2=6.
  - 192 `wr_en` total.
  - `done` at cycle 1 + 6·38 = 229.
